pwm_multi_apb: RTL and testbench
================================

// Module: pwm_multi_apb
// PURPOSE
// - Parametrised multi-channel APB PWM timer; successor to the single-channel PWM peripheral.
// - One shared prescaled timebase drives NCH outputs. Each output has its own duty and polarity.
// - Period/duty writes are double-buffered so updates are glitch-free; period event raises a maskable IRQ.
// - Sits on the 16-bit APB peripheral bus; pready tied 1 (no wait states).
// PARAMETERS
// - NCH    4   number of PWM channels, 1..8
// - CNT_W  16  counter/period/duty width, 2..16; registers zero-extended to 16 bits on read
// - PRE_W  8   prescaler register width, 1..16
// PORTS
// - pclk     in   1      APB/system clock
// - reset    in   1      synchronous, active-high reset
// - paddr    in   10     word address
// - psel     in   1      APB select
// - penable  in   1      APB enable phase
// - pwrite   in   1      1 = write
// - pwdata   in   16     write data
// - prdata   out  16     read data; 0 unless psel&penable&~pwrite
// - pready   out  1      constant 1
// - pwm_out  out  NCH    registered PWM outputs
// - irq      out  1      level interrupt = STATUS.pev & CTRL.ie
// BEHAVIOUR
// - Write strobe: psel&penable&pwrite&pready. Read data is combinational from the addressed register.
// - Map (paddr):
//   - 0 CTRL: b0 run, b1 ie, b2 center
//   - 1 STATUS: b0 pev, RO/W1C
//   - 2 PRESCALE
//   - 3 PERIOD
//   - 4..4+NCH-1 DUTY[i]
//   - 4+NCH POL: NCH bits, 1 = active-low
//   - Unmapped addresses: read 0, writes ignored.
// - Reset: all registers 0, counter 0, prescaler 0, pwm_out 0, irq 0.
// - Shadow registers: PERIOD/DUTY writes land in shadow registers; reads return the shadow value.
// - Active copies load from shadow:
//   - at each period boundary;
//   - every cycle while run=0.
// - Prescaler: pcnt increments every cycle while run=1.
//   - When pcnt==PRESCALE: pcnt<=0 and tick=1.
//   - PRESCALE=0 gives a tick every cycle.
// - Edge mode (center=0), on tick:
//   - counter==per_act-1 -> counter<=0, boundary, pev<=1;
//   - otherwise counter+1.
// - per_act=0: counter held at 0, no boundary, all channels inactive.
// - Channel i active when counter < duty_act[i]:
//   - duty=0 -> never active;
//   - duty>=per_act -> always active.
// - pwm_out[i] <= active[i]^POL[i], registered, so 1 cycle latency from the counter.
// - run=0: pcnt and counter forced to 0; pwm_out = POL (inactive level); no events.
// - Clearing run mid-period aborts the period immediately.
// - STATUS: a W1C write and a new event in the same cycle -> event wins, pev stays 1.
// - The active copy loads and the counter wraps in the same cycle, so the first count of a new period uses the new values.
// - reset asserted mid-operation behaves as full reset on the next edge.
// CONFIGURATION
// - PWM_CENTER_EN defined:
//   - CTRL.center is implemented.
//   - center=1: counter counts up to per_act-1, then down to 0 (triangle).
//   - Boundary, shadow load and pev occur only at counter==0 when turning up.
//   - Output active while counter < duty, giving a symmetric pulse.
//   - Changing center takes effect at the next boundary.
// - PWM_CENTER_EN undefined: CTRL.b2 reads 0, writes ignored, edge mode only.
// TESTING
// - reset; PRESCALE=0, PERIOD=10, DUTY0=3, run=1 -> pwm_out[0] high 3 / low 7 cycles, repeating every 10 cycles.
// - DUTY1=0, DUTY2=10, DUTY3=20 -> out1 constant 0, out2 and out3 constant 1. POL=0x2 -> out1 constant 1.
// - PRESCALE=3, PERIOD=4, DUTY0=2 -> period 16 cycles, high 8. ie=1: irq rises once per period, W1C clears it.
// - Mid-period write DUTY0=1 -> waveform unchanged until next boundary, then high 1 tick per period.
// - Clear run mid-period -> next cycle pwm_out=POL, counter 0; W1C same cycle as pev event -> pev stays 1.
// - [PWM_CENTER_EN] center=1, PERIOD=5, DUTY0=2 -> counter 0,1,2,3,4,3,2,1,0..., out0 high while counter<2.

Source files
------------

// File: rtl/pwm_multi_apb.sv
// rtl/pwm_multi_apb.sv - multi-channel APB PWM timer on one shared prescaled timebase
// Define PWM_CENTER_EN to build the center-aligned (triangle) counting mode.
module pwm_multi_apb #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [9:0]       paddr,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [15:0]      pwdata,
  output logic [15:0]      prdata,
  output logic             pready,
  output logic [NCH-1:0]   pwm_out,
  output logic             irq
);
  localparam logic [9:0] POL_ADDR = 10'(4 + NCH);

  logic                       run, ie, center, pev;
  logic [PRE_W-1:0]           prescale, pcnt;
  logic [CNT_W-1:0]           per_sh, per_act, counter;
  logic [NCH-1:0][CNT_W-1:0]  duty_sh, duty_act;
  logic [NCH-1:0]             pol;
  logic                       center_act, count_up;

  logic                       wr, ctrl_wr, go, tick, boundary;
  logic [CNT_W-1:0]           counter_nxt;
  logic                       count_up_nxt;
  logic [NCH-1:0]             active;

  assign pready  = 1'b1;
  assign wr      = psel & penable & pwrite & pready;
  assign ctrl_wr = wr && (paddr == 10'd0);
  // Clearing run aborts the period on the very edge that writes CTRL.
  assign go      = run & ~(ctrl_wr & ~pwdata[0]);
  assign tick    = go && (pcnt == prescale);
  assign irq     = pev & ie;

  always_ff @(posedge pclk) begin
    if (reset) begin
      run      <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      per_sh   <= '0;
      duty_sh  <= '0;
      pol      <= '0;
    end else if (wr) begin
      if (paddr == 10'd0) begin
        run <= pwdata[0];
        ie  <= pwdata[1];
      end
      if (paddr == 10'd2) prescale <= pwdata[PRE_W-1:0];
      if (paddr == 10'd3) per_sh <= pwdata[CNT_W-1:0];
      for (int i = 0; i < NCH; i++)
        if (paddr == 10'(4 + i)) duty_sh[i] <= pwdata[CNT_W-1:0];
      if (paddr == POL_ADDR) pol <= pwdata[NCH-1:0];
    end
  end

`ifdef PWM_CENTER_EN
  always_ff @(posedge pclk) begin
    if (reset) center <= 1'b0;
    else if (ctrl_wr) center <= pwdata[2];
  end
`else
  assign center = 1'b0;
`endif

  // Triangle mode: a period starts whenever the counter returns to 0 heading up.
  always_comb begin
    counter_nxt  = counter;
    count_up_nxt = count_up;
    boundary     = 1'b0;
    if (tick && per_act != '0) begin
      if (!center_act) begin
        count_up_nxt = 1'b1;
        if (counter == per_act - 1'b1) begin
          counter_nxt = '0;
          boundary    = 1'b1;
        end else begin
          counter_nxt = counter + 1'b1;
        end
      end else if (count_up && counter != per_act - 1'b1) begin
        counter_nxt = counter + 1'b1;
      end else if (counter == '0) begin
        boundary = 1'b1;
      end else begin
        counter_nxt  = counter - 1'b1;
        count_up_nxt = (counter == CNT_W'(1));
        boundary     = (counter == CNT_W'(1));
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NCH; i++)
      active[i] = (per_act != '0) && (counter < duty_act[i]);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      pcnt       <= '0;
      counter    <= '0;
      count_up   <= 1'b1;
      per_act    <= '0;
      duty_act   <= '0;
      center_act <= 1'b0;
      pwm_out    <= '0;
    end else if (!go) begin
      pcnt       <= '0;
      counter    <= '0;
      count_up   <= 1'b1;
      per_act    <= per_sh;
      duty_act   <= duty_sh;
      center_act <= center;
      pwm_out    <= pol;
    end else begin
      pcnt     <= tick ? '0 : pcnt + 1'b1;
      counter  <= counter_nxt;
      count_up <= count_up_nxt;
      pwm_out  <= active ^ pol;
      if (boundary) begin
        per_act    <= per_sh;
        duty_act   <= duty_sh;
        center_act <= center;
      end
    end
  end

  // An event in the same cycle as a W1C write wins.
  always_ff @(posedge pclk) begin
    if (reset) pev <= 1'b0;
    else if (boundary) pev <= 1'b1;
    else if (wr && paddr == 10'd1 && pwdata[0]) pev <= 1'b0;
  end

  always_comb begin
    prdata = '0;
    if (psel && penable && !pwrite) begin
      if (paddr == 10'd0)        prdata = {13'd0, center, ie, run};
      else if (paddr == 10'd1)   prdata = {15'd0, pev};
      else if (paddr == 10'd2)   prdata = 16'(prescale);
      else if (paddr == 10'd3)   prdata = 16'(per_sh);
      else if (paddr == POL_ADDR) prdata = 16'(pol);
      else begin
        for (int i = 0; i < NCH; i++)
          if (paddr == 10'(4 + i)) prdata = 16'(duty_sh[i]);
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_apb.sv
// tb/tb_pwm_multi_apb.sv - self-checking bench for pwm_multi_apb
// Reference model tracks period phase in ticks; counter value is derived from the phase.
module tb_pwm_multi_apb;
  localparam int NCH = 4, CNT_W = 16, PRE_W = 8;

  logic            pclk = 1'b0, reset = 1'b1;
  logic [9:0]      paddr = '0;
  logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0]     pwdata = '0;
  logic [15:0]     prdata;
  logic            pready;
  logic [NCH-1:0]  pwm_out;
  logic            irq;

  pwm_multi_apb #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .pclk(pclk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pwm_out(pwm_out), .irq(irq)
  );

  always #5 pclk = ~pclk;

  int checks = 0, errors = 0, cyc = 0;
  bit check_en = 1'b0;

  bit            m_run, m_ie, m_center, m_pev, m_cen_a;
  int            m_pre, m_per_sh, m_per_a, m_cyc, m_phase;
  int            m_duty_sh[NCH], m_duty_a[NCH];
  bit [NCH-1:0]  m_pol, m_out;

  function automatic int period_ticks(input int p, input bit cen);
    if (cen && p >= 2) return 2 * (p - 1);
    return p;
  endfunction

  function automatic int count_at(input int ph, input int p, input bit cen);
    if (cen && ph >= p) return 2 * (p - 1) - ph;
    return ph;
  endfunction

  function automatic logic [15:0] model_read(input logic [9:0] a);
    if (a == 10'd0) return {13'd0, m_center, m_ie, m_run};
    if (a == 10'd1) return {15'd0, m_pev};
    if (a == 10'd2) return 16'(m_pre);
    if (a == 10'd3) return 16'(m_per_sh);
    if (a >= 10'd4 && a < 10'(4 + NCH)) return 16'(m_duty_sh[int'(a) - 4]);
    if (a == 10'(4 + NCH)) return 16'(m_pol);
    return 16'd0;
  endfunction

  function automatic bit boundary_next();
    return m_run && m_per_a != 0 && m_cyc == m_pre &&
           m_phase == period_ticks(m_per_a, m_cen_a) - 1;
  endfunction

  always @(posedge pclk) begin
    bit we, go, tick, ev;
    int a, cnt;
    cyc++;
    we = psel && penable && pwrite;
    a  = int'(paddr);
    ev = 1'b0;
    if (reset) begin
      m_run = 0; m_ie = 0; m_center = 0; m_pev = 0; m_cen_a = 0;
      m_pre = 0; m_per_sh = 0; m_per_a = 0; m_cyc = 0; m_phase = 0;
      m_pol = '0; m_out = '0;
      foreach (m_duty_sh[i]) begin m_duty_sh[i] = 0; m_duty_a[i] = 0; end
    end else begin
      go = m_run && !(we && a == 0 && !pwdata[0]);
      if (!go) begin
        m_cyc = 0; m_phase = 0;
        m_per_a = m_per_sh; m_duty_a = m_duty_sh; m_cen_a = m_center;
        m_out = m_pol;
      end else begin
        cnt = count_at(m_phase, m_per_a, m_cen_a);
        for (int i = 0; i < NCH; i++)
          m_out[i] = ((m_per_a != 0) && (cnt < m_duty_a[i])) ^ m_pol[i];
        tick = (m_cyc == m_pre);
        m_cyc = tick ? 0 : m_cyc + 1;
        if (tick && m_per_a != 0) begin
          m_phase++;
          if (m_phase == period_ticks(m_per_a, m_cen_a)) begin
            m_phase = 0;
            m_per_a = m_per_sh; m_duty_a = m_duty_sh; m_cen_a = m_center;
            ev = 1'b1;
          end
        end
      end
      if (we) begin
        if (a == 0) begin
          m_run = pwdata[0]; m_ie = pwdata[1];
`ifdef PWM_CENTER_EN
          m_center = pwdata[2];
`endif
        end
        if (a == 2) m_pre = int'(pwdata) % (1 << PRE_W);
        if (a == 3) m_per_sh = int'(pwdata) % (1 << CNT_W);
        if (a >= 4 && a < 4 + NCH) m_duty_sh[a - 4] = int'(pwdata) % (1 << CNT_W);
        if (a == 4 + NCH) m_pol = pwdata[NCH-1:0];
      end
      m_pev = ev || (m_pev && !(we && a == 1 && pwdata[0]));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (check_en) begin
      check("pwm_out_vs_model", 32'(pwm_out), 32'(m_out));
      check("irq_vs_model", 32'(irq), 32'(m_pev & m_ie));
    end
  end

  task automatic apb_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge pclk); paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] a, output logic [15:0] d, output logic [15:0] e);
    @(negedge pclk); paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    #1 check("prdata_setup_zero", 32'(prdata), 32'd0);
    @(negedge pclk); penable = 1'b1;
    #1 d = prdata; e = model_read(a);
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_irq(output int t);
    int n = 0;
    while (irq !== 1'b1 && n < 64) begin @(negedge pclk); n++; end
    t = cyc;
    check("irq_wait", 32'(irq), 32'd1);
  endtask

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        do_write;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [15:0] rd, ex, d;
    logic [9:0]  a;
    int n0, n1, n2, n3, t1, t2;
    bit hit;
`ifdef PWM_CENTER_EN
    logic [15:0] ctrl_exp = 16'h0006;
`else
    logic [15:0] ctrl_exp = 16'h0002;
`endif

    for (int i = 0; i <= 4 + NCH; i++) vt.push_back('{10'(i), 16'd0, 1'b0, 16'd0});
    vt.push_back('{10'd0, 16'hFFFE, 1'b1, ctrl_exp});
    vt.push_back('{10'd2, 16'hABCD, 1'b1, 16'h00CD});
    vt.push_back('{10'd3, 16'h1234, 1'b1, 16'h1234});
    vt.push_back('{10'd4, 16'hFFFF, 1'b1, 16'hFFFF});
    vt.push_back('{10'd7, 16'h0005, 1'b1, 16'h0005});
    vt.push_back('{10'd8, 16'hFFFF, 1'b1, 16'h000F});
    vt.push_back('{10'd9, 16'h5555, 1'b1, 16'h0000});
    vt.push_back('{10'h3FF, 16'hFFFF, 1'b1, 16'h0000});
    vt.push_back('{10'd1, 16'h0001, 1'b1, 16'h0000});

    repeat (3) @(negedge pclk);
    check_en = 1'b1;
    reset = 1'b0;
    check("pready", 32'(pready), 32'd1);
    check("reset_pwm_out", 32'(pwm_out), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);

    foreach (vt[k]) begin
      if (vt[k].do_write) apb_write(vt[k].addr, vt[k].wdata);
      apb_read(vt[k].addr, rd, ex);
      check($sformatf("vec%0d_read", k), 32'(rd), 32'(vt[k].exp));
    end

    // Basic edge PWM and duty extremes.
    apb_write(10'd2, 16'd0);
    apb_write(10'd3, 16'd10);
    apb_write(10'd4, 16'd3);
    apb_write(10'd5, 16'd0);
    apb_write(10'd6, 16'd10);
    apb_write(10'd7, 16'd20);
    apb_write(10'd8, 16'd0);
    apb_write(10'd0, 16'd1);
    repeat (12) @(negedge pclk);
    n0 = 0; n1 = 0; n2 = 0; n3 = 0;
    repeat (30) begin
      @(negedge pclk);
      n0 += int'(pwm_out[0]); n1 += int'(pwm_out[1]);
      n2 += int'(pwm_out[2]); n3 += int'(pwm_out[3]);
    end
    check("duty3_of_10_high", 32'(n0), 32'd9);
    check("duty0_never", 32'(n1), 32'd0);
    check("duty_eq_period", 32'(n2), 32'd30);
    check("duty_gt_period", 32'(n3), 32'd30);
    apb_write(10'd8, 16'h0002);
    repeat (2) @(negedge pclk);
    n1 = 0;
    repeat (20) begin @(negedge pclk); n1 += int'(pwm_out[1]); end
    check("pol_inverts_out1", 32'(n1), 32'd20);

    // Prescaled period, IRQ cadence and W1C.
    apb_write(10'd0, 16'd0);
    apb_write(10'd8, 16'd0);
    apb_write(10'd2, 16'd3);
    apb_write(10'd3, 16'd4);
    apb_write(10'd4, 16'd2);
    apb_write(10'd1, 16'd1);
    apb_write(10'd0, 16'd3);
    repeat (5) @(negedge pclk);
    n0 = 0;
    repeat (64) begin @(negedge pclk); n0 += int'(pwm_out[0]); end
    check("prescaled_high", 32'(n0), 32'd32);
    apb_write(10'd1, 16'd1);
    wait_irq(t1);
    apb_write(10'd1, 16'd1);
    check("irq_w1c_clears", 32'(irq), 32'd0);
    wait_irq(t2);
    check("irq_period", 32'(t2 - t1), 32'd16);

    // Duty change mid-period is held back until the next boundary.
    apb_write(10'd4, 16'd1);
    n0 = 0;
    repeat (5) begin @(negedge pclk); n0 += int'(pwm_out[0]); end
    check("old_duty_kept", 32'(n0), 32'd5);
    repeat (8) @(negedge pclk);
    n0 = 0;
    repeat (16) begin @(negedge pclk); n0 += int'(pwm_out[0]); end
    check("new_duty_after_boundary", 32'(n0), 32'd4);

    // Clearing run mid-period.
    apb_write(10'd8, 16'h0005);
    repeat (3) @(negedge pclk);
    apb_write(10'd0, 16'd0);
    check("stop_out_is_pol", 32'(pwm_out), 32'h5);

    // W1C landing on the same edge as a period event.
    apb_write(10'd8, 16'd0);
    apb_write(10'd2, 16'd0);
    apb_write(10'd3, 16'd4);
    apb_write(10'd0, 16'd3);
    apb_write(10'd1, 16'd1);
    @(negedge pclk);
    paddr = 10'd1; pwdata = 16'd1; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge pclk);
      if (boundary_next()) begin penable = 1'b1; hit = 1'b1; end
    end
    check("w1c_collision_found", 32'(hit), 32'd1);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("event_beats_w1c_irq", 32'(irq), 32'd1);
    apb_read(10'd1, rd, ex);
    check("event_beats_w1c_status", 32'(rd), 32'd1);

`ifdef PWM_CENTER_EN
    apb_write(10'd0, 16'd0);
    apb_write(10'd3, 16'd5);
    apb_write(10'd4, 16'd2);
    apb_write(10'd0, 16'd5);
    repeat (3) @(negedge pclk);
    n0 = 0;
    repeat (32) begin @(negedge pclk); n0 += int'(pwm_out[0]); end
    check("center_high", 32'(n0), 32'd12);
`endif

    // Randomized traffic against the reference model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          a = 10'($urandom_range(0, 9));
          case (a)
            10'd0: begin d = 16'($urandom_range(0, 7)); if ($urandom_range(0, 3) != 0) d[0] = 1'b1; end
            10'd1: d = 16'($urandom_range(0, 1));
            10'd2: d = 16'($urandom_range(0, 3));
            10'd3: d = 16'($urandom_range(0, 12));
            10'd8: d = 16'($urandom_range(0, 15));
            10'd9: d = 16'($urandom);
            default: d = 16'($urandom_range(0, 14));
          endcase
          apb_write(a, d);
        end
        5, 6: begin
          a = 10'($urandom_range(0, 10));
          apb_read(a, rd, ex);
          check("rand_read", 32'(rd), 32'(ex));
        end
        7, 8: repeat ($urandom_range(1, 20)) @(negedge pclk);
        default: begin
          if ($urandom_range(0, 4) == 0) begin
            @(negedge pclk); reset = 1'b1;
            @(negedge pclk); reset = 1'b0;
          end
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
